// File: rtl/brdg_retry_pkg.sv
// Shared definitions for the bridge retry scheduler: escalation state
// encodings, parameter defaults and the backoff code width.
package brdg_retry_pkg;

    localparam int BO_W             = 4;
    localparam int ESC_MAX_DEF      = 8;
    localparam int STARVE_LIMIT_DEF = 16;

    typedef enum logic [1:0] {
        ESC_IDLE     = 2'd0,
        ESC_TRACK    = 2'd1,
        ESC_ESCALATE = 2'd2
    } esc_state_t;

    // Saturating add of base and escalation, clamped to the largest backoff code.
    function automatic logic [BO_W-1:0] backoff_sum(input logic [BO_W-1:0] base,
                                                   input logic [BO_W-1:0] esc);
        logic [BO_W:0] sum;
        sum = {1'b0, base} + {1'b0, esc};
        return (sum > (BO_W+1)'(15)) ? BO_W'(15) : sum[BO_W-1:0];
    endfunction

endpackage

// File: rtl/brdg_retry_sched_esc.sv
// Per-source backoff escalation: tracks the last accepted retry tag/pos and
// raises the backoff limit on repeated retries, relaxing on forward progress.
module brdg_retry_sched_esc
    import brdg_retry_pkg::*;
#(
    parameter int TAGW    = 7,
    parameter int ESC_MAX = ESC_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BO_W-1:0] cfg_backoff_base,
    input  logic            accept,
    input  logic [TAGW-1:0] tag,
    input  logic [1:0]      pos,
    input  logic            rsp_ok,
    output logic [BO_W-1:0] limit
);

    esc_state_t      state_q, state_d;
    logic [BO_W-1:0] esc_q, esc_d;
    logic [TAGW-1:0] last_tag_q, last_tag_d;
    logic [1:0]      last_pos_q, last_pos_d;
    logic [BO_W-1:0] limit_q;
    logic            limit_vld_q;
    logic            same;
    logic [BO_W-1:0] esc_inc;

    assign same    = (tag == last_tag_q) && (pos == last_pos_q);
    assign esc_inc = (esc_q >= BO_W'(ESC_MAX)) ? BO_W'(ESC_MAX) : esc_q + 1'b1;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        esc_d      = esc_q;
        last_tag_d = last_tag_q;
        last_pos_d = last_pos_q;
        if (accept) begin
            // An accept outranks a coincident rsp_ok.
            unique case (state_q)
                ESC_IDLE: begin
                    esc_d      = '0;
                    last_tag_d = tag;
                    last_pos_d = pos;
                    state_d    = ESC_TRACK;
                end
                ESC_TRACK: begin
                    if (same) begin
                        esc_d   = esc_inc;
                        state_d = ESC_ESCALATE;
                    end else begin
                        esc_d      = '0;
                        last_tag_d = tag;
                        last_pos_d = pos;
                    end
                end
                ESC_ESCALATE: begin
                    if (same) begin
                        esc_d = esc_inc;
                    end else begin
                        esc_d      = '0;
                        last_tag_d = tag;
                        last_pos_d = pos;
                        state_d    = ESC_IDLE;
                    end
                end
                default: state_d = ESC_IDLE;
            endcase
        end else if (rsp_ok) begin
            esc_d   = '0;
            state_d = ESC_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ESC_IDLE;
            esc_q       <= '0;
            last_tag_q  <= '0;
            last_pos_q  <= '0;
            limit_q     <= '0;
            limit_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            esc_q       <= esc_d;
            last_tag_q  <= last_tag_d;
            last_pos_q  <= last_pos_d;
            limit_q     <= backoff_sum(cfg_backoff_base, esc_d);
            limit_vld_q <= 1'b1;
        end
    end

    // Until the first registered value exists the limit shows the raw base code.
    assign limit = limit_vld_q ? limit_q : cfg_backoff_base;

endmodule

// File: rtl/brdg_retry_sched.sv
// Retry scheduler sharing one issue slot between NSRC retry queues and the
// new-command path. Optional per-source counters: BRDG_RETRY_SCHED_STATS_EN.
module brdg_retry_sched
    import brdg_retry_pkg::*;
#(
    parameter int NSRC         = 2,
    parameter int TAGW         = 7,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int ESC_MAX      = ESC_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BO_W-1:0]      cfg_backoff_base,
    input  logic [NSRC-1:0]      rq_busy,
    output logic [NSRC-1:0]      rq_rty_rdy,
    input  logic [NSRC-1:0]      rq_rty_valid,
    input  logic [NSRC*TAGW-1:0] rq_rty_tag,
    input  logic [NSRC*2-1:0]    rq_rty_pos,
    output logic [NSRC*BO_W-1:0] rq_backoff_limit,
    input  logic [NSRC-1:0]      rsp_ok,
    input  logic                 new_cmd_req,
    output logic                 new_cmd_gnt,
    output logic                 issue_valid,
    input  logic                 issue_rdy,
    output logic [1:0]           issue_src,
    output logic [TAGW-1:0]      issue_tag,
    output logic [1:0]           issue_pos,
    output logic [NSRC*16-1:0]   stat_rty_cnt
);

    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    logic [1:0]      ptr_q;
    logic [SW-1:0]   starve_q;
    logic            slot_free, force_new, accept;
    logic [NSRC-1:0] acc_vec;
    logic [TAGW-1:0] sel_tag;
    logic [1:0]      sel_pos;

    assign slot_free = ~issue_valid | issue_rdy;
    assign force_new = starve_q >= SW'(STARVE_LIMIT - 1);

    // Offer only to the polled source; the offer never looks at rq_rty_valid.
    always_comb begin
        rq_rty_rdy = '0;
        sel_tag    = '0;
        sel_pos    = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (ptr_q == 2'(i)) begin
                rq_rty_rdy[i] = slot_free & ~force_new & rq_busy[i];
                sel_tag       = rq_rty_tag[i*TAGW +: TAGW];
                sel_pos       = rq_rty_pos[i*2 +: 2];
            end
        end
    end

    assign acc_vec     = rq_rty_valid & rq_rty_rdy;
    assign accept      = |acc_vec;
    assign new_cmd_gnt = slot_free & new_cmd_req & (force_new | ~accept);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            starve_q    <= '0;
            issue_valid <= 1'b0;
            issue_src   <= '0;
            issue_tag   <= '0;
            issue_pos   <= '0;
        end else begin
            ptr_q <= (ptr_q == 2'(NSRC - 1)) ? 2'd0 : ptr_q + 2'd1;
            if (new_cmd_req && !new_cmd_gnt)
                starve_q <= force_new ? starve_q : starve_q + 1'b1;
            else
                starve_q <= '0;
            if (accept) begin
                issue_valid <= 1'b1;
                issue_src   <= ptr_q;
                issue_tag   <= sel_tag;
                issue_pos   <= sel_pos;
            end else if (issue_rdy) begin
                issue_valid <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NSRC; g++) begin : g_esc
        brdg_retry_sched_esc #(
            .TAGW    (TAGW),
            .ESC_MAX (ESC_MAX)
        ) u_esc (
            .clk              (clk),
            .rst_n            (rst_n),
            .cfg_backoff_base (cfg_backoff_base),
            .accept           (acc_vec[g]),
            .tag              (rq_rty_tag[g*TAGW +: TAGW]),
            .pos              (rq_rty_pos[g*2 +: 2]),
            .rsp_ok           (rsp_ok[g]),
            .limit            (rq_backoff_limit[g*BO_W +: BO_W])
        );
    end

`ifdef BRDG_RETRY_SCHED_STATS_EN
    for (genvar g = 0; g < NSRC; g++) begin : g_stat
        logic [15:0] cnt_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)          cnt_q <= '0;
            else if (acc_vec[g]) cnt_q <= cnt_q + 16'd1;
        end
        assign stat_rty_cnt[g*16 +: 16] = cnt_q;
    end
`else
    assign stat_rty_cnt = '0;
`endif

endmodule

// File: tb/tb_brdg_retry_sched.sv
// Directed bench for brdg_retry_sched (NSRC=2): offer/accept, round robin,
// starvation, escalation, clamping and downstream stall.
module tb_brdg_retry_sched;

    localparam int NSRC = 2;
    localparam int TAGW = 7;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [3:0]           cfg_backoff_base;
    logic [NSRC-1:0]      rq_busy, rq_rty_rdy, rq_rty_valid, rsp_ok;
    logic [NSRC*TAGW-1:0] rq_rty_tag;
    logic [NSRC*2-1:0]    rq_rty_pos;
    logic [NSRC*4-1:0]    rq_backoff_limit;
    logic                 new_cmd_req, new_cmd_gnt, issue_valid, issue_rdy;
    logic [1:0]           issue_src, issue_pos;
    logic [TAGW-1:0]      issue_tag;
    logic [NSRC*16-1:0]   stat_rty_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    brdg_retry_sched #(.NSRC(NSRC), .TAGW(TAGW), .STARVE_LIMIT(16), .ESC_MAX(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_backoff_base (cfg_backoff_base),
        .rq_busy          (rq_busy),
        .rq_rty_rdy       (rq_rty_rdy),
        .rq_rty_valid     (rq_rty_valid),
        .rq_rty_tag       (rq_rty_tag),
        .rq_rty_pos       (rq_rty_pos),
        .rq_backoff_limit (rq_backoff_limit),
        .rsp_ok           (rsp_ok),
        .new_cmd_req      (new_cmd_req),
        .new_cmd_gnt      (new_cmd_gnt),
        .issue_valid      (issue_valid),
        .issue_rdy        (issue_rdy),
        .issue_src        (issue_src),
        .issue_tag        (issue_tag),
        .issue_pos        (issue_pos),
        .stat_rty_cnt     (stat_rty_cnt)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reset with idle inputs; returns 1 ns after an edge, pointer at 0 for the next edge.
    task automatic do_reset(input logic [3:0] base);
        rst_n            = 1'b0;
        cfg_backoff_base = base;
        rq_busy          = '0;
        rq_rty_valid     = '0;
        rq_rty_tag       = '0;
        rq_rty_pos       = '0;
        rsp_ok           = '0;
        new_cmd_req      = 1'b0;
        issue_rdy        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(4'd3);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({issue_valid, issue_src, issue_tag, issue_pos, rq_rty_rdy, new_cmd_gnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b src=%0d tag=%h pos=%0d rdy=%b gnt=%b, want all 0",
                     issue_valid, issue_src, issue_tag, issue_pos, rq_rty_rdy, new_cmd_gnt);
        end
        n_cmp++;
        if (rq_backoff_limit !== 8'h33) begin
            n_err++;
            $display("FAIL reset_limit: got %h want 33", rq_backoff_limit);
        end
        n_cmp++;
        if (stat_rty_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_stat: got %h want 0", stat_rty_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset(4'd2);
        issue_rdy    = 1'b1;
        rq_busy      = 2'b01;
        rq_rty_valid = 2'b01;
        rq_rty_tag   = {7'h00, 7'h12};
        rq_rty_pos   = {2'd0, 2'd1};
        #1;
        n_cmp++;
        if (rq_rty_rdy !== 2'b01) begin
            n_err++;
            $display("FAIL single_offer: got rdy=%b want 01", rq_rty_rdy);
        end
        @(posedge clk);
        #1;
        rq_busy      = '0;
        rq_rty_valid = '0;
        n_cmp++;
        if ({issue_valid, issue_src, issue_tag, issue_pos} !== {1'b1, 2'd0, 7'h12, 2'd1}) begin
            n_err++;
            $display("FAIL single_issue: got v=%b src=%0d tag=%h pos=%0d want v=1 src=0 tag=12 pos=1",
                     issue_valid, issue_src, issue_tag, issue_pos);
        end
        n_cmp++;
        if (rq_backoff_limit[3:0] !== 4'd2) begin
            n_err++;
            $display("FAIL single_esc0: got limit0=%0d want 2", rq_backoff_limit[3:0]);
        end
`ifdef BRDG_RETRY_SCHED_STATS_EN
        n_cmp++;
        if (stat_rty_cnt[15:0] !== 16'd1) begin
            n_err++;
            $display("FAIL single_stat: got %0d want 1", stat_rty_cnt[15:0]);
        end
`endif
        cyc();
        n_cmp++;
        if (issue_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_drain: got issue_valid=%b want 0", issue_valid);
        end
    endtask

    task automatic test_alternate();
        do_reset(4'd0);
        issue_rdy    = 1'b1;
        rq_busy      = 2'b11;
        rq_rty_valid = 2'b11;
        rq_rty_tag   = {7'h21, 7'h10};
        rq_rty_pos   = {2'd2, 2'd3};
        for (int i = 0; i < 4; i++) begin
            logic [1:0]      exp_src;
            logic [TAGW-1:0] exp_tag;
            cyc();
            exp_src = 2'(i % 2);
            exp_tag = (i % 2 == 0) ? 7'h10 : 7'h21;
            n_cmp++;
            if ({issue_valid, issue_src, issue_tag} !== {1'b1, exp_src, exp_tag}) begin
                n_err++;
                $display("FAIL alternate_%0d: got v=%b src=%0d tag=%h want v=1 src=%0d tag=%h",
                         i, issue_valid, issue_src, issue_tag, exp_src, exp_tag);
            end
        end
        rq_busy      = '0;
        rq_rty_valid = '0;
    endtask

    // Both queues stay valid so every polled cycle accepts; only the
    // starvation counter can get the new command through.
    task automatic test_starve();
        do_reset(4'd0);
        issue_rdy    = 1'b1;
        rq_busy      = 2'b11;
        rq_rty_valid = 2'b11;
        new_cmd_req  = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            logic exp_gnt;
            #1;
            exp_gnt = (k == 16);
            n_cmp++;
            if (new_cmd_gnt !== exp_gnt) begin
                n_err++;
                $display("FAIL starve_gnt_c%0d: got %b want %b", k, new_cmd_gnt, exp_gnt);
            end
            if (k == 16) begin
                n_cmp++;
                if (rq_rty_rdy !== 2'b00) begin
                    n_err++;
                    $display("FAIL starve_rdy: got %b want 00", rq_rty_rdy);
                end
            end
            cyc();
        end
        new_cmd_req  = 1'b0;
        rq_busy      = '0;
        rq_rty_valid = '0;
    endtask

    task automatic test_escalate();
        logic [3:0] exp;
        do_reset(4'd3);
        issue_rdy    = 1'b1;
        rq_busy      = 2'b10;
        rq_rty_valid = 2'b10;
        rq_rty_tag   = {7'h05, 7'h00};
        rq_rty_pos   = {2'd2, 2'd0};
        for (int n = 1; n <= 10; n++) begin
            cyc();  // src0 polled, idle
            cyc();  // src1 polled, accept registered
            exp = (n - 1 > 8) ? 4'd11 : 4'(3 + n - 1);
            n_cmp++;
            if (rq_backoff_limit !== {exp, 4'd3}) begin
                n_err++;
                $display("FAIL escalate_n%0d: got limit1=%0d limit0=%0d want %0d/3",
                         n, rq_backoff_limit[7:4], rq_backoff_limit[3:0], exp);
            end
        end
        rq_busy      = '0;
        rq_rty_valid = '0;
        rsp_ok       = 2'b10;
        cyc();
        rsp_ok = '0;
        n_cmp++;
        if (rq_backoff_limit[7:4] !== 4'd3) begin
            n_err++;
            $display("FAIL escalate_rsp_ok: got %0d want 3", rq_backoff_limit[7:4]);
        end
    endtask

    task automatic test_clamp();
        logic [3:0] exp;
        do_reset(4'd14);
        issue_rdy    = 1'b1;
        rq_busy      = 2'b01;
        rq_rty_valid = 2'b01;
        rq_rty_tag   = {7'h00, 7'h33};
        rq_rty_pos   = {2'd0, 2'd0};
        for (int n = 1; n <= 4; n++) begin
            cyc();  // src0 polled, accept registered
            exp = (n == 1) ? 4'd14 : 4'd15;
            n_cmp++;
            if (rq_backoff_limit[3:0] !== exp) begin
                n_err++;
                $display("FAIL clamp_n%0d: got %0d want %0d", n, rq_backoff_limit[3:0], exp);
            end
            cyc();
        end
        rq_busy      = '0;
        rq_rty_valid = '0;
    endtask

    task automatic test_stall();
        int bad;
        do_reset(4'd0);
        issue_rdy    = 1'b0;
        new_cmd_req  = 1'b1;
        rq_busy      = 2'b01;
        rq_rty_valid = 2'b01;
        rq_rty_tag   = {7'h00, 7'h44};
        rq_rty_pos   = {2'd0, 2'd3};
        cyc();  // empty slot accepts src0, the retry wins the grant
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            n_cmp++;
            if ({issue_valid, issue_src, issue_tag, issue_pos, rq_rty_rdy, new_cmd_gnt}
                !== {1'b1, 2'd0, 7'h44, 2'd3, 2'b00, 1'b0}) begin
                n_err++;
                bad++;
                if (bad <= 3)
                    $display("FAIL stall_c%0d: got v=%b src=%0d tag=%h pos=%0d rdy=%b gnt=%b want 1/0/44/3/00/0",
                             k, issue_valid, issue_src, issue_tag, issue_pos, rq_rty_rdy, new_cmd_gnt);
            end
            cyc();
        end
`ifdef BRDG_RETRY_SCHED_STATS_EN
        n_cmp++;
        if (stat_rty_cnt[15:0] !== 16'd1) begin
            n_err++;
            $display("FAIL stall_stat: got %0d want 1", stat_rty_cnt[15:0]);
        end
`endif
        // Starved request is now forced: grant, no offer.
        issue_rdy = 1'b1;
        #1;
        n_cmp++;
        if ({new_cmd_gnt, rq_rty_rdy} !== 3'b100) begin
            n_err++;
            $display("FAIL stall_release: got gnt=%b rdy=%b want gnt=1 rdy=00", new_cmd_gnt, rq_rty_rdy);
        end
        cyc();
        n_cmp++;
        if (issue_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_drain: got issue_valid=%b want 0", issue_valid);
        end
        new_cmd_req  = 1'b0;
        rq_busy      = '0;
        rq_rty_valid = '0;
    endtask

    task automatic test_idle_grant();
        do_reset(4'd0);
        issue_rdy   = 1'b0;
        new_cmd_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if ({new_cmd_gnt, rq_rty_rdy} !== 3'b100) begin
                n_err++;
                $display("FAIL idle_gnt_c%0d: got gnt=%b rdy=%b want gnt=1 rdy=00", k, new_cmd_gnt, rq_rty_rdy);
            end
            cyc();
        end
        new_cmd_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_starve();
        test_escalate();
        test_clamp();
        test_stall();
        test_idle_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
